// File: rtl/control_fsm_if.sv
// control_fsm_if: memory request/ready handshake between control_fsm and the memory
interface control_fsm_if;
   logic mem_req;
   logic mem_ready;
   modport master (output mem_req, input mem_ready);
   modport slave (input mem_req, output mem_ready);
endinterface

// File: rtl/control_fsm.sv
// control_fsm: multicycle RISC-V control unit; define CONTROL_FSM_JAL_EN to include the JAL state
module control_fsm #(
   parameter int MEM_HANDSHAKE = 1
) (
   input  logic                clk,
   input  logic                reset,
   control_fsm_if.master       bus,
   input  logic [6:0]          op,
   input  logic [2:0]          funct3,
   input  logic                funct7b5,
   input  logic                Zero,
   output logic                PCWrite,
   output logic                IRWrite,
   output logic                RegWrite,
   output logic                MemWrite,
   output logic                AdrSrc,
   output logic [1:0]          ResultSrc,
   output logic [1:0]          ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [1:0]          ImmSrc,
   output logic [2:0]          ALUControl,
   output logic                illegal_op
);
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ
`ifdef CONTROL_FSM_JAL_EN
      , JAL
`endif
   } state_t;
   state_t state, next;
   logic ready, mem_req, alu_bad;
   logic [2:0] alu_dec;
   assign ready = (MEM_HANDSHAKE == 0) | bus.mem_ready;
   assign bus.mem_req = mem_req;
   assign ImmSrc = (op == 7'b0100011) ? 2'b01 :
                   (op == 7'b1100011) ? 2'b10 :
                   (op == 7'b1101111) ? 2'b11 : 2'b00;
   // ALU operation for the execute states; only R-type honours funct7b5 for sub
   always_comb begin
      alu_bad = 1'b0;
      case (funct3)
         3'b000:  alu_dec = (state == EXECUTER && funct7b5) ? 3'b001 : 3'b000;
         3'b010:  alu_dec = 3'b101;
         3'b110:  alu_dec = 3'b011;
         3'b111:  alu_dec = 3'b010;
         default: begin alu_dec = 3'b000; alu_bad = 1'b1; end
      endcase
   end
   // next state and outputs; reset drops every enable and steers back to FETCH
   always_comb begin
      next = state;
      mem_req = 1'b0;
      PCWrite = 1'b0;
      IRWrite = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      AdrSrc = 1'b0;
      illegal_op = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA = 2'b00;
      ALUSrcB = 2'b00;
      ALUControl = 3'b000;
      if (reset) next = FETCH;
      else case (state)
         FETCH: begin
            mem_req = 1'b1;
            ALUSrcB = 2'b10;
            ResultSrc = 2'b10;
            IRWrite = ready;
            PCWrite = ready;
            next = ready ? DECODE : FETCH;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               7'b0000011, 7'b0100011: next = MEMADR;
               7'b0110011: next = EXECUTER;
               7'b0010011: next = EXECUTEI;
               7'b1100011: next = BEQ;
`ifdef CONTROL_FSM_JAL_EN
               7'b1101111: next = JAL;
`endif
               default: begin next = FETCH; illegal_op = 1'b1; end
            endcase
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            next = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            mem_req = 1'b1;
            AdrSrc = 1'b1;
            next = ready ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite = 1'b1;
            next = FETCH;
         end
         MEMWRITE: begin
            mem_req = 1'b1;
            AdrSrc = 1'b1;
            MemWrite = ready;
            next = ready ? FETCH : MEMWRITE;
         end
         EXECUTER: begin
            ALUSrcA = 2'b10;
            ALUControl = alu_dec;
            illegal_op = alu_bad;
            next = ALUWB;
         end
         EXECUTEI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUControl = alu_dec;
            illegal_op = alu_bad;
            next = ALUWB;
         end
         ALUWB: begin
            RegWrite = 1'b1;
            next = FETCH;
         end
         BEQ: begin
            ALUSrcA = 2'b10;
            ALUControl = 3'b001;
            PCWrite = Zero;
            next = FETCH;
         end
`ifdef CONTROL_FSM_JAL_EN
         JAL: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            PCWrite = 1'b1;
            next = ALUWB;
         end
`endif
         default: next = FETCH;
      endcase
   end
   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else state <= next;
   end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: scoreboard bench for control_fsm; per-cycle stimulus and expected outputs are queued together
module tb_control_fsm;
   logic clk = 1'b0, reset = 1'b1, rdy = 1'b0, Zero = 1'b0, funct7b5 = 1'b0;
   logic [6:0] op = 7'b0;
   logic [2:0] funct3 = 3'b0;
   logic PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, illegal_op;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [17:0] obs, exp_v;
   logic [13:0] stim;
   logic [13:0] sq[$];
   logic [17:0] eq[$];
   logic [6:0] n_op;
   logic [2:0] n_f3;
   logic n_f7;
   logic [1:0] cur_imm;
   int passed = 0, total = 0;
   control_fsm_if bus();
   assign bus.mem_ready = rdy;
   control_fsm dut (
      .clk(clk), .reset(reset), .bus(bus), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .ALUControl(ALUControl), .illegal_op(illegal_op)
   );
   assign obs = {bus.mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
                 ImmSrc, ALUControl, illegal_op};
   always #5 clk = ~clk;
   // expected output vectors: {mem_req,PCW,IRW,RegW,MemW,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,illegal}
   function automatic logic [17:0] v_fetch(input logic r);
      return {1'b1, r, r, 3'b000, 2'b10, 2'b00, 2'b10, cur_imm, 3'b000, 1'b0};
   endfunction
   function automatic logic [17:0] v_decode(input logic ill);
      return {6'b0, 2'b00, 2'b01, 2'b01, cur_imm, 3'b000, ill};
   endfunction
   function automatic logic [17:0] v_exec(input logic [1:0] sb, input logic [2:0] alu, input logic ill);
      return {6'b0, 2'b00, 2'b10, sb, cur_imm, alu, ill};
   endfunction
   function automatic logic [17:0] v_aluwb();
      return {6'b000100, 2'b00, 2'b00, 2'b00, cur_imm, 3'b000, 1'b0};
   endfunction
   function automatic logic [17:0] v_memadr();
      return {6'b0, 2'b00, 2'b10, 2'b01, cur_imm, 3'b000, 1'b0};
   endfunction
   function automatic logic [17:0] v_mem(input logic mw);
      return {4'b1000, mw, 1'b1, 2'b00, 2'b00, 2'b00, cur_imm, 3'b000, 1'b0};
   endfunction
   function automatic logic [17:0] v_memwb();
      return {6'b000100, 2'b01, 2'b00, 2'b00, cur_imm, 3'b000, 1'b0};
   endfunction
   function automatic logic [17:0] v_beq(input logic z);
      return {1'b0, z, 4'b0000, 2'b00, 2'b10, 2'b00, cur_imm, 3'b001, 1'b0};
   endfunction
   function automatic logic [17:0] v_jal();
      return {6'b010000, 2'b00, 2'b01, 2'b10, cur_imm, 3'b000, 1'b0};
   endfunction
   function automatic logic [17:0] v_reset();
      return {6'b0, 2'b00, 2'b00, 2'b00, cur_imm, 3'b000, 1'b0};
   endfunction
   task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic [1:0] imm);
      n_op = o; n_f3 = f3; n_f7 = f7; cur_imm = imm;
   endtask
   task automatic push(input logic r, input logic rd, input logic z, input logic [17:0] e);
      sq.push_back({r, rd, z, n_op, n_f3, n_f7});
      eq.push_back(e);
   endtask
   task automatic test_reset();
      set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
      push(1, 1, 0, v_reset()); push(1, 0, 0, v_reset());
      push(0, 1, 0, v_fetch(1)); push(0, 1, 0, v_decode(0)); push(0, 1, 0, v_memadr()); push(0, 1, 0, v_mem(1));
      while (eq.size() != 0) begin
         @(negedge clk);
         stim = sq.pop_front();
         {reset, rdy, Zero, op, funct3, funct7b5} = stim;
         exp_v = eq.pop_front();
         #1; total++;
         if (obs !== exp_v) $display("FAIL reset step %0d: got %h expected %h", total, obs, exp_v); else passed++;
      end
   endtask
   task automatic test_alu();
      set_instr(7'b0110011, 3'b000, 1'b0, 2'b00);
      push(0, 1, 0, v_fetch(1)); push(0, 1, 0, v_decode(0)); push(0, 1, 0, v_exec(2'b00, 3'b000, 0)); push(0, 1, 0, v_aluwb());
      set_instr(7'b0110011, 3'b000, 1'b1, 2'b00);
      push(0, 1, 0, v_fetch(1)); push(0, 1, 0, v_decode(0)); push(0, 1, 0, v_exec(2'b00, 3'b001, 0)); push(0, 1, 0, v_aluwb());
      set_instr(7'b0010011, 3'b000, 1'b1, 2'b00);
      push(0, 1, 0, v_fetch(1)); push(0, 1, 0, v_decode(0)); push(0, 1, 0, v_exec(2'b01, 3'b000, 0)); push(0, 1, 0, v_aluwb());
      set_instr(7'b0110011, 3'b010, 1'b0, 2'b00);
      push(0, 1, 0, v_fetch(1)); push(0, 1, 0, v_decode(0)); push(0, 1, 0, v_exec(2'b00, 3'b101, 0)); push(0, 1, 0, v_aluwb());
      set_instr(7'b0010011, 3'b110, 1'b0, 2'b00);
      push(0, 1, 0, v_fetch(1)); push(0, 1, 0, v_decode(0)); push(0, 1, 0, v_exec(2'b01, 3'b011, 0)); push(0, 1, 0, v_aluwb());
      set_instr(7'b0110011, 3'b111, 1'b0, 2'b00);
      push(0, 1, 0, v_fetch(1)); push(0, 1, 0, v_decode(0)); push(0, 1, 0, v_exec(2'b00, 3'b010, 0)); push(0, 1, 0, v_aluwb());
      set_instr(7'b0010011, 3'b001, 1'b0, 2'b00);
      push(0, 1, 0, v_fetch(1)); push(0, 1, 0, v_decode(0)); push(0, 1, 0, v_exec(2'b01, 3'b000, 1)); push(0, 1, 0, v_aluwb());
      while (eq.size() != 0) begin
         @(negedge clk);
         stim = sq.pop_front();
         {reset, rdy, Zero, op, funct3, funct7b5} = stim;
         exp_v = eq.pop_front();
         #1; total++;
         if (obs !== exp_v) $display("FAIL alu step %0d: got %h expected %h", total, obs, exp_v); else passed++;
      end
   endtask
   task automatic test_beq();
      set_instr(7'b1100011, 3'b000, 1'b0, 2'b10);
      push(0, 1, 1, v_fetch(1)); push(0, 1, 1, v_decode(0)); push(0, 1, 1, v_beq(1));
      push(0, 1, 0, v_fetch(1)); push(0, 1, 0, v_decode(0)); push(0, 1, 0, v_beq(0));
      push(0, 0, 0, v_fetch(0));
      while (eq.size() != 0) begin
         @(negedge clk);
         stim = sq.pop_front();
         {reset, rdy, Zero, op, funct3, funct7b5} = stim;
         exp_v = eq.pop_front();
         #1; total++;
         if (obs !== exp_v) $display("FAIL beq step %0d: got %h expected %h", total, obs, exp_v); else passed++;
      end
   endtask
   task automatic test_lw_wait();
      set_instr(7'b0000011, 3'b010, 1'b0, 2'b00);
      push(0, 1, 0, v_fetch(1)); push(0, 1, 0, v_decode(0)); push(0, 1, 0, v_memadr());
      for (int i = 0; i < 3; i++) push(0, 0, 0, v_mem(0));
      push(0, 1, 0, v_mem(0)); push(0, 1, 0, v_memwb()); push(0, 0, 0, v_fetch(0));
      while (eq.size() != 0) begin
         @(negedge clk);
         stim = sq.pop_front();
         {reset, rdy, Zero, op, funct3, funct7b5} = stim;
         exp_v = eq.pop_front();
         #1; total++;
         if (obs !== exp_v) $display("FAIL lw_wait step %0d: got %h expected %h", total, obs, exp_v); else passed++;
      end
   endtask
   task automatic test_sw_reset_mid();
      set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
      push(0, 0, 0, v_fetch(0)); push(0, 0, 0, v_fetch(0)); push(0, 1, 0, v_fetch(1));
      push(0, 1, 0, v_decode(0)); push(0, 1, 0, v_memadr()); push(0, 0, 0, v_mem(0)); push(0, 0, 0, v_mem(0));
      push(1, 1, 0, v_reset()); push(1, 0, 0, v_reset());
      push(0, 0, 0, v_fetch(0)); push(0, 1, 0, v_fetch(1)); push(0, 1, 0, v_decode(0));
      push(0, 1, 0, v_memadr()); push(0, 1, 0, v_mem(1)); push(0, 0, 0, v_fetch(0));
      while (eq.size() != 0) begin
         @(negedge clk);
         stim = sq.pop_front();
         {reset, rdy, Zero, op, funct3, funct7b5} = stim;
         exp_v = eq.pop_front();
         #1; total++;
         if (obs !== exp_v) $display("FAIL sw_reset_mid step %0d: got %h expected %h", total, obs, exp_v); else passed++;
      end
   endtask
   task automatic test_illegal();
      set_instr(7'b1111111, 3'b000, 1'b0, 2'b00);
      push(0, 1, 0, v_fetch(1)); push(0, 1, 0, v_decode(1)); push(0, 0, 0, v_fetch(0)); push(0, 0, 0, v_fetch(0));
`ifdef CONTROL_FSM_JAL_EN
      set_instr(7'b1101111, 3'b000, 1'b0, 2'b11);
      push(0, 1, 0, v_fetch(1)); push(0, 1, 0, v_decode(0)); push(0, 1, 0, v_jal()); push(0, 1, 0, v_aluwb());
`else
      set_instr(7'b1101111, 3'b000, 1'b0, 2'b11);
      push(0, 1, 0, v_fetch(1)); push(0, 1, 0, v_decode(1)); push(0, 0, 0, v_fetch(0));
`endif
      while (eq.size() != 0) begin
         @(negedge clk);
         stim = sq.pop_front();
         {reset, rdy, Zero, op, funct3, funct7b5} = stim;
         exp_v = eq.pop_front();
         #1; total++;
         if (obs !== exp_v) $display("FAIL illegal_jal step %0d: got %h expected %h", total, obs, exp_v); else passed++;
      end
   endtask
   task automatic test_back_to_back();
      set_instr(7'b0000011, 3'b010, 1'b0, 2'b00);
      push(0, 1, 0, v_fetch(1)); push(0, 1, 0, v_decode(0)); push(0, 1, 0, v_memadr()); push(0, 1, 0, v_mem(0)); push(0, 1, 0, v_memwb());
      set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
      push(0, 1, 0, v_fetch(1)); push(0, 1, 0, v_decode(0)); push(0, 1, 0, v_memadr()); push(0, 1, 0, v_mem(1));
      set_instr(7'b1100011, 3'b000, 1'b0, 2'b10);
      push(0, 1, 1, v_fetch(1)); push(0, 1, 1, v_decode(0)); push(0, 1, 1, v_beq(1)); push(0, 0, 0, v_fetch(0));
      while (eq.size() != 0) begin
         @(negedge clk);
         stim = sq.pop_front();
         {reset, rdy, Zero, op, funct3, funct7b5} = stim;
         exp_v = eq.pop_front();
         #1; total++;
         if (obs !== exp_v) $display("FAIL back_to_back step %0d: got %h expected %h", total, obs, exp_v); else passed++;
      end
   endtask
   initial begin
      test_reset();
      test_alu();
      test_beq();
      test_lw_wait();
      test_sw_reset_mid();
      test_illegal();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
